// File: rtl/pfb_pkg.sv
// ============================================================================
// Module      : pfb_pkg
// Description : Shared types and defaults for the instruction prefetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pfb_pkg;

    localparam int          c_depth_default    = 4;
    localparam logic [31:0] c_reset_pc_default = 32'h0000_0000;
    localparam logic [31:0] c_nop              = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pfb_fifo.sv
// ============================================================================
// Module      : pfb_fifo
// Description : In-order DEPTH x 64 FIFO of fetch entries, push/pop/clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pfb_fifo
    import pfb_pkg::*;
#(
    parameter int DEPTH = c_depth_default,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/instr_prefetch_buffer.sv
// ============================================================================
// Module      : instr_prefetch_buffer
// Description : Sequential instruction prefetcher with in-order FIFO and
//               redirect flush. Define PREFETCH_BYPASS_EN to let a response
//               reach fetch combinationally when the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_prefetch_buffer
    import pfb_pkg::*;
#(
    parameter int          DEPTH    = c_depth_default,
    parameter logic [31:0] RESET_PC = c_reset_pc_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;
    logic [SW-1:0] w_inflight;
    logic          w_grant;
    logic          w_accept;
    logic          w_discard;
    logic          w_fifo_has;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;

    // Every slot is either buffered, awaiting a kept response, or awaiting a discard.
    assign w_inflight = {2'b00, w_count} + {2'b00, live_q} + {2'b00, drop_q};
    assign mem_req_o  = (w_inflight < SW'(DEPTH));
    assign mem_addr_o = fetch_pc_q;

    assign w_grant    = mem_req_o & mem_gnt_i;
    assign w_accept   = mem_rvalid_i & (drop_q == '0);
    assign w_discard  = mem_rvalid_i & (drop_q != '0);
    assign w_fifo_has = (w_count != '0);

`ifdef PREFETCH_BYPASS_EN
    assign w_bypass = w_accept & ~w_fifo_has;
`else
    assign w_bypass = 1'b0;
`endif

    assign instr_valid_o = (w_fifo_has | w_bypass) & ~redirect_i;
    assign instr_o       = w_fifo_has ? w_head.instr : (w_bypass ? mem_rdata_i : '0);
    assign instr_pc_o    = w_fifo_has ? w_head.pc    : (w_bypass ? rsp_pc_q    : '0);

    assign w_pop       = w_fifo_has & instr_valid_o & instr_ready_i;
    assign w_push      = w_accept & ~redirect_i & ~(w_bypass & instr_ready_i);
    assign w_push_data = '{instr: mem_rdata_i, pc: rsp_pc_q};

    pfb_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (redirect_i),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        live_d     = live_q;
        drop_d     = drop_q;
        if (redirect_i) begin
            // Everything still owed by memory, including this cycle's grant, becomes a discard.
            fetch_pc_d = word_align(redirect_pc_i);
            rsp_pc_d   = word_align(redirect_pc_i);
            drop_d     = drop_q + live_q + {{(CW-1){1'b0}}, w_grant}
                         - {{(CW-1){1'b0}}, mem_rvalid_i};
            live_d     = '0;
        end else begin
            if (w_grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (w_accept) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            live_d = live_q + {{(CW-1){1'b0}}, w_grant} - {{(CW-1){1'b0}}, w_accept};
            drop_d = drop_q - {{(CW-1){1'b0}}, w_discard};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            live_q     <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_buffer.sv
// ============================================================================
// Module      : tb_instr_prefetch_buffer
// Description : Directed self-checking bench for instr_prefetch_buffer
//               (honours PREFETCH_BYPASS_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_prefetch_buffer;

`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    instr_prefetch_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rs;
        bit          rdy;
        bit          v;
        logic [31:0] pc;
        bit          req;
        logic [31:0] addr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          acc;
        int          cyc;
    } rec_t;

    vec_t  tbl[$];
    pend_t pend[$];
    rec_t  recs[$];
    int    lat;
    int    cyc;
    int    n_total;
    int    n_bad;
    int    rc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic vec_t mk(input bit rs, input bit rdy, input bit v,
                                input logic [31:0] pc, input bit req, input logic [31:0] addr);
        vec_t t;
        t.rs = rs; t.rdy = rdy; t.v = v; t.pc = pc; t.req = req; t.addr = addr;
        return t;
    endfunction

    function automatic int count_acc();
        int n = 0;
        foreach (recs[i]) if (recs[i].acc) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: observe at negedge, let memory see the grant, then present the
    // response due in the new cycle.
    task automatic step();
        @(negedge clk);
        if (!rst && instr_valid_o) recs.push_back('{instr_pc_o, instr_o, instr_ready_i, cyc});
        if (!rst && mem_req_o && mem_gnt_i) pend.push_back('{mem_addr_o, cyc + lat});
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = word_of(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        redirect_i   = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mem_gnt_i    = 1'b1;
        lat          = 1;
        pend.delete();
        recs.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_until(input int n);
        for (int k = 0; k < 60 && count_acc() < n; k++) step();
    endtask

    task automatic check_stream(input string nm, input logic [31:0] base, input int n);
        int j;
        j = 0;
        chk({nm, " accepted"}, 32'(count_acc() >= n), 32'd1);
        chk({nm, " first pc"}, (recs.size() > 0) ? recs[0].pc : 32'hDEAD_BEEF, base);
        foreach (recs[i]) begin
            chk($sformatf("%s data@%h", nm, recs[i].pc), recs[i].instr, word_of(recs[i].pc));
            if (recs[i].acc && j < n) begin
                chk($sformatf("%s order%0d", nm, j), recs[i].pc, base + 32'(4 * j));
                j++;
            end
        end
    endtask

    initial begin
        n_total = 0; n_bad = 0; cyc = 0; lat = 1; rc = 0;
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0; instr_ready_i = 1'b0;

        // Stream from reset, single-cycle memory, fetch always ready.
        tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h0));
`ifdef PREFETCH_BYPASS_EN
        tbl.push_back(mk(0, 1, 1, 32'h0,  1, 32'h4));
        tbl.push_back(mk(0, 1, 1, 32'h4,  1, 32'h8));
        tbl.push_back(mk(0, 1, 1, 32'h8,  1, 32'hC));
        tbl.push_back(mk(0, 1, 1, 32'hC,  1, 32'h10));
        tbl.push_back(mk(0, 1, 1, 32'h10, 1, 32'h14));
`else
        tbl.push_back(mk(0, 1, 0, 32'h0,  1, 32'h4));
        tbl.push_back(mk(0, 1, 1, 32'h0,  1, 32'h8));
        tbl.push_back(mk(0, 1, 1, 32'h4,  1, 32'hC));
        tbl.push_back(mk(0, 1, 1, 32'h8,  1, 32'h10));
        tbl.push_back(mk(0, 1, 1, 32'hC,  1, 32'h14));
`endif
        // Backpressure from reset: four grants, then stall until ready returns.
        tbl.push_back(mk(1, 0, 0, 32'h0, 1, 32'h0));
        tbl.push_back(mk(0, 0, BYP, 32'h0, 1, 32'h4));
        tbl.push_back(mk(0, 0, 1, 32'h0, 1, 32'h8));
        tbl.push_back(mk(0, 0, 1, 32'h0, 1, 32'hC));
        for (int k = 0; k < 6; k++) tbl.push_back(mk(0, 0, 1, 32'h0, 0, 32'h10));
        tbl.push_back(mk(0, 1, 1, 32'h0,  0, 32'h10));
        tbl.push_back(mk(0, 1, 1, 32'h4,  1, 32'h10));
        tbl.push_back(mk(0, 1, 1, 32'h8,  1, 32'h14));
        tbl.push_back(mk(0, 1, 1, 32'hC,  1, 32'h18));
        tbl.push_back(mk(0, 1, 1, 32'h10, 1, 32'h1C));
        tbl.push_back(mk(0, 1, 1, 32'h14, 1, 32'h20));

        foreach (tbl[i]) begin
            if (tbl[i].rs) do_reset();
            instr_ready_i = tbl[i].rdy;
            #2;
            chk($sformatf("vec%0d req", i),   {31'b0, mem_req_o},     {31'b0, tbl[i].req});
            chk($sformatf("vec%0d addr", i),  mem_addr_o,             tbl[i].addr);
            chk($sformatf("vec%0d valid", i), {31'b0, instr_valid_o}, {31'b0, tbl[i].v});
            if (tbl[i].v || tbl[i].rs) begin
                chk($sformatf("vec%0d pc", i),    instr_pc_o, tbl[i].v ? tbl[i].pc : 32'h0);
                chk($sformatf("vec%0d instr", i), instr_o,    tbl[i].v ? word_of(tbl[i].pc) : 32'h0);
            end
            step();
        end

        // Redirect with two requests outstanding at latency 3.
        do_reset();
        lat = 3; instr_ready_i = 1'b1;
        step(); step();
        mem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
        recs.delete();
        step();
        redirect_i = 1'b0; mem_gnt_i = 1'b1;
        #2;
        chk("C redirect addr", mem_addr_o, 32'h100);
        chk("C redirect req", {31'b0, mem_req_o}, 32'd1);
        run_until(3);
        check_stream("C", 32'h100, 3);

        // Redirect coincident with a grant and a response: two discards follow.
        do_reset();
        lat = 2; instr_ready_i = 1'b1;
        step(); step();
        chk("D rvalid in redirect cycle", {31'b0, mem_rvalid_i}, 32'd1);
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        recs.delete();
        rc = cyc;
        step();
        redirect_i = 1'b0;
        #2;
        chk("D redirect addr", mem_addr_o, 32'h100);
        run_until(3);
        check_stream("D", 32'h100, 3);
        chk("D first valid cycle", (recs.size() > 0) ? 32'(recs[0].cyc) : 32'hFFFF_FFFF,
            32'(rc + (BYP ? 3 : 4)));

        // Fetch address wraps; low target bits are ignored.
        do_reset();
        instr_ready_i = 1'b1;
        step(); step(); step();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        recs.delete();
        step();
        redirect_i = 1'b0;
        #2;
        chk("E addr target", mem_addr_o, 32'hFFFF_FFFC);
        step();
        #2;
        chk("E addr wrapped", mem_addr_o, 32'h0000_0000);
        run_until(3);
        check_stream("E", 32'hFFFF_FFFC, 3);

        // Asynchronous reset between edges with the FIFO full.
        do_reset();
        instr_ready_i = 1'b0;
        repeat (8) step();
        #2;
        chk("F full req", {31'b0, mem_req_o}, 32'd0);
        chk("F full valid", {31'b0, instr_valid_o}, 32'd1);
        rst = 1'b1;
        mem_rvalid_i = 1'b0;
        pend.delete();
        #1;
        chk("F rst valid", {31'b0, instr_valid_o}, 32'd0);
        chk("F rst instr", instr_o, 32'h0);
        chk("F rst pc",    instr_pc_o, 32'h0);
        chk("F rst req",   {31'b0, mem_req_o}, 32'd1);
        chk("F rst addr",  mem_addr_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        recs.delete();
        instr_ready_i = 1'b1;
        run_until(3);
        check_stream("F", 32'h0, 3);
        chk("F first valid cycle", (recs.size() > 0) ? 32'(recs[0].cyc) : 32'hFFFF_FFFF,
            BYP ? 32'd1 : 32'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
